// File: rtl/frame_read_arbiter_if.sv
// ----------------------------------------------------------------------------
// frame_read_arbiter_if
// Bundle between the frame BRAM read arbiter and its surroundings: the pixel
// requesters plus the BRAM read port.
//   req_in        requester i wants one pixel read (bit per requester)
//   addr_in       requester i address in [i*ADDR_W +: ADDR_W]
//   gnt_out       one-hot one-cycle pulse, read of requester i accepted
//   bram_addr_out registered address to the BRAM read port
//   bram_data_in  BRAM read data, READ_LATENCY cycles after the address
//   rvalid_out    one-hot pulse, returned pixel belongs to requester i
//   rdata_out     returned pixel (1 = white), qualified by rvalid_out
//   busy_out      a read is in flight in the latency pipeline
// Modports: slave = arbiter, master = requesters together with the BRAM.
// ----------------------------------------------------------------------------
interface frame_read_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 20
);
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic [ADDR_W-1:0]         bram_addr_out;
    logic                      bram_data_in;
    logic [NUM_REQ-1:0]        rvalid_out;
    logic                      rdata_out;
    logic                      busy_out;

    modport slave (
        input  req_in,
        input  addr_in,
        input  bram_data_in,
        output gnt_out,
        output bram_addr_out,
        output rvalid_out,
        output rdata_out,
        output busy_out
    );

    modport master (
        output req_in,
        output addr_in,
        output bram_data_in,
        input  gnt_out,
        input  bram_addr_out,
        input  rvalid_out,
        input  rdata_out,
        input  busy_out
    );
endinterface

// File: rtl/frame_read_arbiter.sv
// ----------------------------------------------------------------------------
// frame_read_arbiter
// Shares the single 1-bpp frame BRAM read port between NUM_REQ pixel readers.
// One read is granted per cycle with round-robin priority; the BRAM address
// is registered on the grant edge and the returned pixel is routed back to
// the issuing requester READ_LATENCY+1 cycles after its gnt_out pulse.
// Ports:
//   clk_in  system clock, rising edge
//   rst_in  asynchronous active-low reset
//   bus     frame_read_arbiter_if.slave (requester and BRAM signals)
// ----------------------------------------------------------------------------
module frame_read_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                 clk_in,
    input logic                 rst_in,
    frame_read_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    // Arbitration
    logic                    active_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        ptr_d;
    logic                    found;
    logic                    grant_en;
    logic [PTR_W-1:0]        win_idx;
    logic [NUM_REQ-1:0]      win_oh;
    logic [ADDR_W-1:0]       win_addr;
    int unsigned             cand;

    // Registered outputs and return path
    logic [NUM_REQ-1:0]      gnt_q;
    logic [ADDR_W-1:0]       bram_addr_q;
    logic [READ_LATENCY-1:0] tag_vld_q;
    logic [NUM_REQ-1:0]      tag_id_q [READ_LATENCY];
    logic                    smp_vld_q;
    logic [NUM_REQ-1:0]      smp_id_q;
    logic                    smp_data_q;
    logic [NUM_REQ-1:0]      rvalid_q;
    logic                    rdata_q;

    // Round-robin search: start at the pointer, wrap modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req_in[PTR_W'(cand)]) begin
                found   = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    // active_q blocks the grant on the first edge after reset release.
    assign grant_en = found & active_q;
    assign win_addr = bus.addr_in[32'(win_idx)*ADDR_W +: ADDR_W];

    always_comb begin
        win_oh = '0;
        if (grant_en) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en) begin
            if (32'(win_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active_q    <= 1'b0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            bram_addr_q <= '0;
            tag_vld_q   <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
            smp_vld_q   <= 1'b0;
            smp_id_q    <= '0;
            smp_data_q  <= 1'b0;
            rvalid_q    <= '0;
            rdata_q     <= 1'b0;
        end else begin
            active_q <= 1'b1;
            ptr_q    <= ptr_d;
            gnt_q    <= win_oh;
            if (grant_en) begin
                bram_addr_q <= win_addr;
            end

            // Stage 0 holds the read whose address is loaded on this edge.
            tag_vld_q[0] <= grant_en;
            tag_id_q[0]  <= win_oh;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end

            // BRAM data is valid READ_LATENCY edges after the address edge;
            // capture it with the tag that has just left the pipeline.
            smp_vld_q  <= tag_vld_q[READ_LATENCY-1];
            smp_id_q   <= tag_id_q[READ_LATENCY-1];
            smp_data_q <= bus.bram_data_in;

            rvalid_q <= smp_vld_q ? smp_id_q : '0;
            if (smp_vld_q) begin
                rdata_q <= smp_data_q;
            end
        end
    end

    assign bus.gnt_out       = gnt_q;
    assign bus.bram_addr_out = bram_addr_q;
    assign bus.rvalid_out    = rvalid_q;
    assign bus.rdata_out     = rdata_q;
    assign bus.busy_out      = |tag_vld_q;

endmodule
